// File: rtl/spi_reg_pkg.sv
// Shared state encoding, register-file geometry and command-byte layout for spi_reg_responder.
package spi_reg_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  localparam int REG_COUNT     = 32;
  localparam int ADDR_W        = 5;
  localparam int CMD_ADDR_MSB  = 7;
  localparam int CMD_ADDR_LSB  = 3;
  localparam int CMD_DIR_BIT   = 1;
  localparam int DEF_HIRQ_ADDR = 25;
  localparam int DEF_HIEN_ADDR = 26;
endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes SCLK/SS_n/MOSI into the system clock and flags SCLK edges.
// Latency: SYNC_STAGES clk to outputs; edge flags are one-cycle pulses; no backpressure.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_sclk,
  input  logic i_ss_n,
  input  logic i_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_ss_active,
  output logic o_mosi_s
);
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   w_sclk_s;

  // Pure synchronizers: left unreset so an in-progress frame is still seen right after reset.
  always_ff @(posedge i_clk) begin
    r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
    r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss_n};
    r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
    r_sclk_prev <= w_sclk_s;
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign o_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign o_sclk_fall = ~w_sclk_s & r_sclk_prev;
  assign o_ss_active = ~r_ss_sync[SYNC_STAGES-1];
  assign o_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder over a 32x8 register file with W1C HIRQ and int_n; SPI_REG_RESPONDER_AUTOINC_EN enables burst address increment.
// Latency: SPI byte commits SYNC_STAGES+1 clk after its 8th SCLK rise, loc_rdata 1 clk; no backpressure, the SPI master sets the pace.
module spi_reg_responder
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HIRQ_ADDR   = DEF_HIRQ_ADDR,
  parameter int HIEN_ADDR   = DEF_HIEN_ADDR
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              spi_SCLK,
  input  logic              spi_SS_n,
  input  logic              spi_MOSI,
  output logic              spi_MISO,
  output logic              spi_MISO_oe,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [7:0]        loc_wdata,
  output logic [7:0]        loc_rdata,
  input  logic [7:0]        irq_set,
  output logic              int_n
);
  localparam logic [ADDR_W-1:0] LP_HIRQ = ADDR_W'(HIRQ_ADDR);
  localparam logic [ADDR_W-1:0] LP_HIEN = ADDR_W'(HIEN_ADDR);

  logic w_sclk_rise, w_sclk_fall, w_ss_active, w_mosi_s;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
    .i_clk       (clk_clk),
    .i_sclk      (spi_SCLK),
    .i_ss_n      (spi_SS_n),
    .i_mosi      (spi_MOSI),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_ss_active (w_ss_active),
    .o_mosi_s    (w_mosi_s)
  );

  state_t            r_state, w_state_nxt;
  logic              r_ss_prev;
  logic [2:0]        r_bit_cnt;
  logic [6:0]        r_rx_shreg;
  logic [7:0]        r_tx_shreg;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic              r_skip_fall;
  logic              r_miso_oe;
  logic              r_int_n;
  logic [7:0]        r_loc_rdata;
  logic [7:0]        r_regs     [REG_COUNT];
  logic [7:0]        w_regs_nxt [REG_COUNT];

  logic              w_ss_fall, w_byte_done, w_spi_we, w_tx_load;
  logic [7:0]        w_rx_byte;
  logic [ADDR_W-1:0] w_addr_inc, w_next_addr;

  always_comb begin
    w_ss_fall   = w_ss_active & ~r_ss_prev;
    w_rx_byte   = {r_rx_shreg, w_mosi_s};
    w_byte_done = w_ss_active && w_sclk_rise && (r_state != ST_IDLE) && (r_bit_cnt == 3'd7);
    w_spi_we    = w_byte_done && (r_state == ST_DATA) && r_write;
    w_addr_inc  = r_addr;
`ifdef SPI_REG_RESPONDER_AUTOINC_EN
    w_addr_inc  = r_addr + ADDR_W'(1);
`endif
    w_next_addr = (r_state == ST_CMD) ? w_rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB] : w_addr_inc;
    w_tx_load   = 1'b0;
    if (w_byte_done) begin
      if (r_state == ST_CMD) w_tx_load = ~w_rx_byte[CMD_DIR_BIT];
      else                   w_tx_load = ~r_write;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!w_ss_active) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_ss_fall)   w_state_nxt = ST_CMD;
        ST_CMD:  if (w_byte_done) w_state_nxt = ST_DATA;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) r_state <= ST_IDLE;
    else                r_state <= w_state_nxt;
  end

  // SPI write beats a same-cycle local write; irq_set beats a same-cycle W1C.
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      w_regs_nxt[i] = r_regs[i];
      if (loc_we && loc_addr == ADDR_W'(i))   w_regs_nxt[i] = loc_wdata;
      if (w_spi_we && r_addr == ADDR_W'(i))   w_regs_nxt[i] = w_rx_byte;
    end
    if (w_spi_we && r_addr == LP_HIRQ) w_regs_nxt[LP_HIRQ] = r_regs[LP_HIRQ] & ~w_rx_byte;
    w_regs_nxt[LP_HIRQ] = w_regs_nxt[LP_HIRQ] | irq_set;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= 8'h00;
      r_ss_prev   <= 1'b1;
      r_bit_cnt   <= 3'd0;
      r_rx_shreg  <= 7'd0;
      r_tx_shreg  <= 8'h00;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_skip_fall <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_int_n     <= 1'b1;
      r_loc_rdata <= 8'h00;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= w_regs_nxt[i];
      r_ss_prev   <= w_ss_active;
      r_miso_oe   <= w_ss_active;
      r_int_n     <= ~|(r_regs[LP_HIRQ] & r_regs[LP_HIEN]);
      r_loc_rdata <= w_regs_nxt[loc_addr];
      if (!w_ss_active || r_state == ST_IDLE) begin
        r_bit_cnt   <= 3'd0;
        r_skip_fall <= 1'b0;
        r_tx_shreg  <= (r_state == ST_IDLE && w_ss_fall) ? r_regs[LP_HIRQ] : 8'h00;
      end else begin
        if (w_sclk_rise) begin
          r_rx_shreg <= w_rx_byte[6:0];
          r_bit_cnt  <= r_bit_cnt + 3'd1;
        end
        if (w_byte_done) begin
          r_addr <= w_next_addr;
          if (r_state == ST_CMD) r_write <= w_rx_byte[CMD_DIR_BIT];
        end
        // A freshly loaded byte must present its MSB for a full SCLK period.
        if (w_tx_load) begin
          r_tx_shreg  <= r_regs[w_next_addr];
          r_skip_fall <= 1'b1;
        end else if (w_sclk_fall) begin
          if (r_skip_fall) r_skip_fall <= 1'b0;
          else             r_tx_shreg  <= {r_tx_shreg[6:0], 1'b0};
        end
      end
    end
  end

  assign spi_MISO    = r_tx_shreg[7];
  assign spi_MISO_oe = r_miso_oe;
  assign loc_rdata   = r_loc_rdata;
  assign int_n       = r_int_n;
endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder: SPI master model plus local-port stimulus with hand-computed expectations.
module tb_spi_reg_responder;
  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic       spi_SCLK, spi_SS_n, spi_MOSI;
  logic       spi_MISO, spi_MISO_oe;
  logic       loc_we;
  logic [4:0] loc_addr;
  logic [7:0] loc_wdata, loc_rdata, irq_set;
  logic       int_n;

  int n_chk = 0;
  int n_err = 0;

  logic       coll_en = 1'b0;
  logic       coll_we = 1'b0;
  logic [7:0] coll_wdata = 8'h00;
  logic [7:0] coll_irq = 8'h00;
  logic [7:0] coll_exp = 8'h00;

  spi_reg_responder dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .spi_SCLK      (spi_SCLK),
    .spi_SS_n      (spi_SS_n),
    .spi_MOSI      (spi_MOSI),
    .spi_MISO      (spi_MISO),
    .spi_MISO_oe   (spi_MISO_oe),
    .loc_we        (loc_we),
    .loc_addr      (loc_addr),
    .loc_wdata     (loc_wdata),
    .loc_rdata     (loc_rdata),
    .irq_set       (irq_set),
    .int_n         (int_n)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic loc_wr(input logic [4:0] a, input logic [7:0] d);
    loc_we = 1'b1; loc_addr = a; loc_wdata = d;
    tick(1);
    loc_we = 1'b0;
  endtask

  task automatic loc_rd(input logic [4:0] a, output logic [7:0] d);
    loc_addr = a;
    tick(1);
    d = loc_rdata;
  endtask

  task automatic ss_low();
    spi_SS_n = 1'b0;
    tick(6);
  endtask

  task automatic ss_high();
    tick(4);
    spi_SS_n = 1'b1;
    tick(6);
  endtask

  // Shifts nbits of tx MSB-first; collision stimulus rides the commit cycle of the byte's last rise.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_MOSI = tx[i];
      tick(4);
      rx[i] = spi_MISO;
      spi_SCLK = 1'b1;
      tick(2);
      if (coll_en && i == 0) begin
        loc_we = coll_we; loc_wdata = coll_wdata; irq_set = coll_irq;
      end
      tick(1);
      if (coll_en && i == 0) begin
        check("coll_rdata", {24'd0, loc_rdata}, {24'd0, coll_exp});
        loc_we = 1'b0; irq_set = 8'h00;
      end
      tick(1);
      spi_SCLK = 1'b0;
    end
  endtask

  logic [7:0] rx, rd;

  initial begin
    reset_reset_n = 1'b0;
    spi_SCLK = 1'b0; spi_SS_n = 1'b1; spi_MOSI = 1'b0;
    loc_we = 1'b0; loc_addr = 5'd0; loc_wdata = 8'h00; irq_set = 8'h00;
    tick(5);
    check("rst_miso", {31'd0, spi_MISO}, 32'd0);
    check("rst_oe", {31'd0, spi_MISO_oe}, 32'd0);
    check("rst_int_n", {31'd0, int_n}, 32'd1);
    check("rst_rdata", {24'd0, loc_rdata}, 32'd0);
    reset_reset_n = 1'b1;
    tick(3);
    loc_rd(5'd10, rd); check("rst_reg10", {24'd0, rd}, 32'd0);

    // SPI write to reg 10
    ss_low();
    check("oe_active", {31'd0, spi_MISO_oe}, 32'd1);
    spi_xfer(8'h52, 8, rx); check("wr_status", {24'd0, rx}, 32'h00);
    spi_xfer(8'hA5, 8, rx);
    ss_high();
    check("oe_idle", {31'd0, spi_MISO_oe}, 32'd0);
    loc_rd(5'd10, rd); check("wr_reg10", {24'd0, rd}, 32'hA5);

    // SPI read of reg 3, status shows HIRQ
    loc_wr(5'd25, 8'h80);
    loc_wr(5'd3, 8'h3C);
    loc_wr(5'd4, 8'h4D);
    ss_low();
    spi_xfer(8'h18, 8, rx); check("rd_status", {24'd0, rx}, 32'h80);
    spi_xfer(8'h00, 8, rx); check("rd_byte1", {24'd0, rx}, 32'h3C);
    spi_xfer(8'h00, 8, rx);
`ifdef SPI_REG_RESPONDER_AUTOINC_EN
    check("rd_byte2", {24'd0, rx}, 32'h4D);
`else
    check("rd_byte2", {24'd0, rx}, 32'h3C);
`endif
    ss_high();

    // W1C clears only the written-one bits
    loc_wr(5'd25, 8'h0F);
    ss_low();
    spi_xfer(8'hCA, 8, rx); check("w1c_status", {24'd0, rx}, 32'h0F);
    spi_xfer(8'h05, 8, rx);
    ss_high();
    loc_rd(5'd25, rd); check("w1c_hirq", {24'd0, rd}, 32'h0A);

    // Interrupt raise and clear
    loc_wr(5'd26, 8'h01);
    tick(2);
    check("int_idle", {31'd0, int_n}, 32'd1);
    irq_set = 8'h01;
    tick(1);
    irq_set = 8'h00;
    check("int_lag", {31'd0, int_n}, 32'd1);
    tick(1);
    check("int_assert", {31'd0, int_n}, 32'd0);
    ss_low();
    spi_xfer(8'hCA, 8, rx); check("int_status", {24'd0, rx}, 32'h0B);
    spi_xfer(8'h01, 8, rx);
    ss_high();
    check("int_clear", {31'd0, int_n}, 32'd1);
    loc_rd(5'd25, rd); check("int_hirq", {24'd0, rd}, 32'h0A);

    // irq_set wins over same-cycle W1C
    loc_addr = 5'd25;
    ss_low();
    spi_xfer(8'hCA, 8, rx);
    coll_en = 1'b1; coll_we = 1'b0; coll_irq = 8'h02; coll_exp = 8'h02;
    spi_xfer(8'h0A, 8, rx);
    coll_en = 1'b0; coll_irq = 8'h00;
    ss_high();

    // SPI write wins over same-cycle local write
    loc_addr = 5'd10;
    ss_low();
    spi_xfer(8'h52, 8, rx);
    coll_en = 1'b1; coll_we = 1'b1; coll_wdata = 8'h99; coll_exp = 8'h77;
    spi_xfer(8'h77, 8, rx);
    coll_en = 1'b0; coll_we = 1'b0;
    ss_high();
    loc_rd(5'd10, rd); check("coll_reg10", {24'd0, rd}, 32'h77);

    // Abort after 5 data bits, then a clean frame
    loc_wr(5'd7, 8'h5A);
    ss_low();
    spi_xfer(8'h3A, 8, rx);
    spi_xfer(8'hFF, 5, rx);
    ss_high();
    loc_rd(5'd7, rd); check("abort_reg7", {24'd0, rd}, 32'h5A);
    ss_low();
    spi_xfer(8'h3A, 8, rx);
    spi_xfer(8'hC3, 8, rx);
    ss_high();
    loc_rd(5'd7, rd); check("after_abort_reg7", {24'd0, rd}, 32'hC3);

    // Burst write at address 31
    loc_wr(5'd0, 8'h99);
    ss_low();
    spi_xfer(8'hFA, 8, rx);
    spi_xfer(8'h11, 8, rx);
    spi_xfer(8'h22, 8, rx);
    ss_high();
    loc_rd(5'd31, rd);
`ifdef SPI_REG_RESPONDER_AUTOINC_EN
    check("burst_reg31", {24'd0, rd}, 32'h11);
    loc_rd(5'd0, rd); check("burst_reg0", {24'd0, rd}, 32'h22);
`else
    check("burst_reg31", {24'd0, rd}, 32'h22);
    loc_rd(5'd0, rd); check("burst_reg0", {24'd0, rd}, 32'h99);
`endif

    // Reset in the middle of a data byte
    loc_wr(5'd25, 8'h01);
    tick(2);
    check("pre_rst_int", {31'd0, int_n}, 32'd0);
    ss_low();
    spi_xfer(8'hFA, 8, rx);
    spi_xfer(8'hFF, 3, rx);
    reset_reset_n = 1'b0;
    tick(1);
    check("mid_rst_int_n", {31'd0, int_n}, 32'd1);
    check("mid_rst_oe", {31'd0, spi_MISO_oe}, 32'd0);
    check("mid_rst_miso", {31'd0, spi_MISO}, 32'd0);
    reset_reset_n = 1'b1;
    tick(1);
    check("post_rst_oe", {31'd0, spi_MISO_oe}, 32'd1);
    spi_xfer(8'hFF, 5, rx);
    ss_high();
    for (int a = 0; a < 32; a++) begin
      loc_rd(5'(a), rd);
      check($sformatf("post_rst_reg%0d", a), {24'd0, rd}, 32'h00);
    end
    check("post_rst_int_n", {31'd0, int_n}, 32'd1);
    ss_low();
    spi_xfer(8'h52, 8, rx);
    spi_xfer(8'h3E, 8, rx);
    ss_high();
    loc_rd(5'd10, rd); check("post_rst_write", {24'd0, rd}, 32'h3E);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
